// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the MIPS core. Holds the fetch address,
//   steps it by INCR on every enabled cycle and applies a branch/jump
//   redirect after exactly one delay-slot instruction. A redirect to
//   address 0 halts the sequencer; only reset leaves the halted state.
//
// Parameters
//   WIDTH         address width in bits
//   RESET_VECTOR  pc_out after reset (truncated to WIDTH)
//   INCR          sequential increment in bytes
//
// Ports
//   clk              in   clock, all state updates on posedge
//   reset            in   synchronous active-high reset, overrides all inputs
//   clk_enable       in   1 = advance one step, 0 = hold everything (stall)
//   redirect_valid   in   branch/jump taken by the instruction at pc_out
//   redirect_target  in   destination address, used when redirect_valid=1
//   pc_out           out  current fetch address (registered)
//   link_addr        out  pc_out + 2*INCR, combinational return address
//   in_delay_slot    out  1 while pc_out is a delay-slot instruction
//   active           out  1 = running, 0 = halted (registered)
//   addr_err         out  sticky misaligned-target flag
//   state_dbg        out  raw FSM state (0=RUN, 1=DELAY, 2=HALT)
//
// Handshake: there is no backpressure. redirect_valid/redirect_target are
//   sampled only on an edge where clk_enable=1 and the FSM is in RUN; in
//   every other case they are ignored and need not be held.
//
// Build option
//   PC_ALIGN_CHECK_EN  when defined, a redirect whose target has bits [1:0]
//                      nonzero is rejected: addr_err sets (sticky) and the
//                      sequencer halts after the delay-slot step. When
//                      undefined, targets are used unchanged and addr_err
//                      is tied to 0.
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          INCR         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] link_addr,
  output logic             in_delay_slot,
  output logic             active,
  output logic             addr_err,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] LINK_OFS = WIDTH'(2 * INCR);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             active_q, active_d;

`ifdef PC_ALIGN_CHECK_EN
  logic             addr_err_q, addr_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
`ifdef PC_ALIGN_CHECK_EN
    addr_err_d = addr_err_q;
`endif
    if (clk_enable) begin
      unique case (state_q)
        ST_RUN: begin
          // The instruction after a branch (delay slot) is always fetched.
          pc_d = pc_q + STEP;
          if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
              addr_err_d = 1'b1;
              state_d    = ST_HALT;
            end else begin
              pending_d = redirect_target;
              state_d   = ST_DELAY;
            end
`else
            pending_d = redirect_target;
            state_d   = ST_DELAY;
`endif
          end
        end
        ST_DELAY: begin
          // A branch sitting in the delay slot is ignored: first target wins.
          pc_d    = pending_q;
          state_d = (pending_q == '0) ? ST_HALT : ST_RUN;
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase
    end
    active_d = (state_d != ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      active_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end
  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

  assign pc_out        = pc_q;
  assign link_addr     = pc_q + LINK_OFS;
  assign in_delay_slot = (state_q == ST_DELAY);
  assign active        = active_q;
  assign state_dbg     = state_q;

endmodule
